hazard_forward_ctrl: RTL and testbench

//  Generates the 2-bit operand-select codes for the EX-stage forwarding muxes, plus the stall/bubble controls.

---
 rtl/mips_hazard_pkg.sv | 22 ++
 rtl/mdu_busy_counter.sv | 42 ++++
 rtl/hazard_forward_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the hazard/forwarding control block.
//   FWD_*          : operand-select codes driven to the EX-stage forwarding muxes
//   stage_entry_t  : one shadow-pipeline slot {valid, dst, reg_write, mem_read}
//   STAGE_W        : packed width of one slot (used for the debug view)
package mips_hazard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  localparam int DST_W = 5;

  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
    logic             reg_write;
    logic             mem_read;
  } stage_entry_t;

  localparam int STAGE_W = $bits(stage_entry_t);

endpackage

// File: rtl/mdu_busy_counter.sv
// Busy tracker for the multiply/divide unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : a mult/div start was accepted this cycle
//   busy       : HI/LO are not yet valid for a reader in ID
// The cycle in which the start is accepted is the first of the LATENCY busy
// cycles, so the counter loads LATENCY-1 and busy covers the remaining ones.
// A mflo directly behind a mult therefore waits LATENCY-1 cycles in ID.
// LATENCY is limited to 1..15 (4-bit counter).
module mdu_busy_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LATENCY - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// Sits beside the ID/EX register and keeps its own shadow copy of the
// {valid, dst, reg_write, mem_read} of the instructions in EX, MEM and WB.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rs, id_rt        source registers of the ID instruction
//   id_dst              destination of the ID instruction
//   id_reg_write        ID instruction writes the regfile
//   id_mem_read         ID instruction is a load
//   id_mdu_start        ID instruction starts mult/div
//   id_uses_hilo        ID instruction reads HI/LO
//   flush_id            kill the ID instruction (taken branch/jump)
//   fwd_a_sel/fwd_b_sel registered EX mux selects: 00 regfile, 01 WB, 10 MEM
//   stall_if/stall_id   hold PC / IF-ID register
//   bubble_ex           load a NOP into ID/EX
//   dbg_shadow          {WB, MEM, EX} shadow slots; a bubble is an all-zero slot
//
// Optional feature, macro HAZARD_BRANCH_FWD_EN: adds id_is_branch input and
// fwd_br_a/fwd_br_b outputs for branch comparison in ID.
//
// All stall outputs are one combinational signal, re-evaluated every cycle;
// flush_id always wins over a stall.
module hazard_forward_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MDU_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mdu_start,
  input  logic              id_uses_hilo,
  input  logic              flush_id,
`ifdef HAZARD_BRANCH_FWD_EN
  input  logic              id_is_branch,
  output logic              fwd_br_a,
  output logic              fwd_br_b,
`endif
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [3*STAGE_W-1:0] dbg_shadow
);

  stage_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic         lu, mdu, br_hz, stall, accept, mdu_load, mdu_busy;

  // A stage produces r when it is a live register write to a non-zero r.
  function automatic logic match_f(input stage_entry_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.dst == r) && (r != '0);
  endfunction

  // The younger producer (EX now, MEM when the consumer is in EX) wins.
  function automatic logic [1:0] sel_f(input stage_entry_t ex_e, input stage_entry_t mem_e,
                                       input logic [REG_AW-1:0] r);
    logic [1:0] s;
    s = FWD_REGFILE;
    if (match_f(ex_e, r)) begin
      s = FWD_MEM;
    end else if (match_f(mem_e, r)) begin
      s = FWD_WB;
    end
    return s;
  endfunction

  always_comb begin
    lu = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.dst != '0) &&
         ((ex_q.dst == id_rs) || (ex_q.dst == id_rt));
    mdu = id_valid && mdu_busy && (id_uses_hilo || id_mdu_start);
`ifdef HAZARD_BRANCH_FWD_EN
    // Branch compares in ID: an EX producer is too young to forward, and a
    // load in MEM has no data yet.
    br_hz = id_valid && id_is_branch &&
            (match_f(ex_q, id_rs) || match_f(ex_q, id_rt) ||
             (mem_q.mem_read && (match_f(mem_q, id_rs) || match_f(mem_q, id_rt))));
`else
    br_hz = 1'b0;
`endif
    stall    = (lu || mdu || br_hz) && !flush_id;
    accept   = id_valid && !flush_id && !stall;
    mdu_load = accept && id_mdu_start;

    ex_d = '0;
    if (accept) begin
      ex_d.valid     = 1'b1;
      ex_d.dst       = id_dst;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;
    if (accept) begin
      fwd_a_d = sel_f(ex_q, mem_q, id_rs);
      fwd_b_d = sel_f(ex_q, mem_q, id_rt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  mdu_busy_counter #(
    .LATENCY(MDU_LATENCY)
  ) u_mdu_busy (
    .clk  (clk),
    .rst_n(rst_n),
    .load (mdu_load),
    .busy (mdu_busy)
  );

`ifdef HAZARD_BRANCH_FWD_EN
  assign fwd_br_a = match_f(mem_q, id_rs);
  assign fwd_br_b = match_f(mem_q, id_rt);
`endif

  assign fwd_a_sel  = fwd_a_q;
  assign fwd_b_sel  = fwd_b_q;
  assign stall_if   = stall;
  assign stall_id   = stall;
  assign bubble_ex  = stall;
  assign dbg_shadow = {wb_q, mem_q, ex_q};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_reg_write, id_mem_read, id_mdu_start, id_uses_hilo, flush_id;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if, stall_id, bubble_ex;
  logic [23:0] dbg_shadow;
`ifdef HAZARD_BRANCH_FWD_EN
  logic        id_is_branch = 1'b0;
  logic        fwd_br_a, fwd_br_b;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: three pipeline slots, index 0 = EX, 1 = MEM, 2 = WB.
  logic       m_v[3];
  logic [4:0] m_dst[3];
  logic       m_rw[3];
  logic       m_mr[3];
  int         cyc;
  int         last_start;

  hazard_forward_ctrl #(.REG_AW(5), .MDU_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mdu_start(id_mdu_start), .id_uses_hilo(id_uses_hilo), .flush_id(flush_id),
`ifdef HAZARD_BRANCH_FWD_EN
    .id_is_branch(id_is_branch), .fwd_br_a(fwd_br_a), .fwd_br_b(fwd_br_b),
`endif
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .dbg_shadow(dbg_shadow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic rw, input logic mr,
                        input logic ms, input logic uh);
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_reg_write = rw; id_mem_read = mr; id_mdu_start = ms; id_uses_hilo = uh;
    flush_id = 1'b0;
  endtask

  task automatic set_nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    set_nop();
    repeat (6) step();
  endtask

  // Model helpers
  function automatic logic [1:0] exp_sel(input logic [4:0] r);
    if (r != 0 && m_v[0] && m_rw[0] && m_dst[0] == r) return 2'b10;
    if (r != 0 && m_v[1] && m_rw[1] && m_dst[1] == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp_slot(input int i);
    return {m_v[i], m_dst[i], m_rw[i], m_mr[i]};
  endfunction

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    set_nop();
    step();
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex});
    end
    checks++;
    if (dbg_shadow !== 24'h0) begin
      failures++;
      $display("FAIL reset_shadow: got %h required 000000", dbg_shadow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fwd_ex();
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);      // add $3
    step();
    set_id(1, 5'd3, 5'd5, 5'd6, 1, 0, 0, 0);      // sub uses $3 as rs
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      failures++; $display("FAIL fwd_ex_stall: got %b required 0", stall_if);
    end
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin
      failures++; $display("FAIL fwd_ex_sel: got a=%b b=%b required a=10 b=00", fwd_a_sel, fwd_b_sel);
    end
    drain();
  endtask

  task automatic test_fwd_mem();
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);      // add $3
    step();
    set_nop();
    step();
    set_id(1, 5'd7, 5'd3, 5'd8, 1, 0, 0, 0);      // or uses $3 as rt
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin
      failures++; $display("FAIL fwd_mem_sel: got a=%b b=%b required a=00 b=01", fwd_a_sel, fwd_b_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 5'd1, 5'd0, 5'd4, 1, 1, 0, 0);      // lw $4
    step();
    set_id(1, 5'd4, 5'd4, 5'd6, 1, 0, 0, 0);      // add $6, $4, $4
    #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b111) begin
      failures++; $display("FAIL load_use_stall: got %b required 111", {stall_if, stall_id, bubble_ex});
    end
    step();
    #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
      failures++; $display("FAIL load_use_once: got %b required 000", {stall_if, stall_id, bubble_ex});
    end
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin
      failures++; $display("FAIL load_use_sel: got a=%b b=%b required a=01 b=01", fwd_a_sel, fwd_b_sel);
    end
    drain();
  endtask

  task automatic test_r0();
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0);      // add $0
    step();
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0);      // lw $0
    step();
    set_id(1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0);      // use $0 twice
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      failures++; $display("FAIL r0_stall: got %b required 0", stall_if);
    end
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      failures++; $display("FAIL r0_sel: got a=%b b=%b required 00 00", fwd_a_sel, fwd_b_sel);
    end
    drain();
  endtask

  task automatic test_mdu();
    int nst;
    set_id(1, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0);      // mult
    step();
    set_id(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 1);      // mflo $5
    nst = 0;
    #1;
    while (stall_if === 1'b1 && nst < 12) begin
      nst++;
      step();
      #1;
    end
    checks++;
    if (nst !== L - 1) begin
      failures++; $display("FAIL mdu_stall_cycles: got %0d required %0d", nst, L - 1);
    end
    step();
    checks++;
    if (dbg_shadow[7] !== 1'b1) begin
      failures++; $display("FAIL mdu_mflo_issued: ex valid got %b required 1", dbg_shadow[7]);
    end
    drain();
    // flush during an MDU stall
    set_id(1, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0);
    step();
    set_id(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 1);
    #1;
    checks++;
    if (stall_if !== 1'b1) begin
      failures++; $display("FAIL mdu_flush_pre: got %b required 1", stall_if);
    end
    flush_id = 1'b1;
    #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
      failures++; $display("FAIL mdu_flush_drop: got %b required 000", {stall_if, stall_id, bubble_ex});
    end
    step();
    checks++;
    if (dbg_shadow[7] !== 1'b0) begin
      failures++; $display("FAIL mdu_flush_bubble: ex valid got %b required 0", dbg_shadow[7]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_id(1, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0);      // mult: counter busy
    step();
    set_id(1, 5'd1, 5'd2, 5'd4, 1, 0, 0, 0);      // add $4
    step();
    set_id(1, 5'd4, 5'd0, 5'd5, 1, 1, 0, 0);      // lw $5, 0($4)
    step();
    set_id(1, 5'd5, 5'd1, 5'd7, 1, 0, 0, 0);      // add uses $5
    #1;
    checks++;
    if ({fwd_a_sel, stall_if} !== 3'b101) begin
      failures++; $display("FAIL rstmid_pre: got a=%b stall=%b required a=10 stall=1", fwd_a_sel, stall_if);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex} !== 7'b0) begin
      failures++;
      $display("FAIL rstmid_async: got %b required 0000000",
               {fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex});
    end
    #2;
    rst_n = 1'b1;
    set_id(1, 5'd4, 5'd5, 5'd8, 1, 0, 0, 1);      // mflo-like reader of $4/$5
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_stall: got %b required 0", stall_if);
    end
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_no_stale: got a=%b b=%b required 00 00", fwd_a_sel, fwd_b_sel);
    end
    drain();
  endtask

  task automatic test_random();
    logic       m_lu, m_mdu, m_stall, acc;
    logic [1:0] e_a, e_b;
    int         k;
    rst_n = 1'b0;
    set_nop();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_dst[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
    end
    cyc = 0;
    last_start = -1000;
    for (int n = 0; n < 400; n++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_dst       = 5'($urandom_range(0, 7));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = id_reg_write && ($urandom_range(0, 3) == 0);
      id_mdu_start = ($urandom_range(0, 19) == 0);
      id_uses_hilo = ($urandom_range(0, 9) == 0);
      flush_id     = ($urandom_range(0, 15) == 0);
      #1;
      // HI/LO are unavailable for the L-1 cycles following an accepted start.
      k       = cyc - last_start;
      m_mdu   = id_valid && (k >= 1) && (k < L) && (id_uses_hilo || id_mdu_start);
      m_lu    = id_valid && m_v[0] && m_mr[0] && m_rw[0] && (m_dst[0] != 0) &&
                ((m_dst[0] == id_rs) || (m_dst[0] == id_rt));
      m_stall = (m_lu || m_mdu) && !flush_id;
      checks++;
      if ({stall_if, stall_id, bubble_ex} !== {3{m_stall}}) begin
        failures++;
        $display("FAIL rand_stall n=%0d: got %b required %b", n,
                 {stall_if, stall_id, bubble_ex}, {3{m_stall}});
      end
      acc = id_valid && !flush_id && !m_stall;
      e_a = acc ? exp_sel(id_rs) : 2'b00;
      e_b = acc ? exp_sel(id_rt) : 2'b00;
      if (acc && id_mdu_start) last_start = cyc;
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_dst[i] = m_dst[i-1]; m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      m_v[0]   = acc;
      m_dst[0] = acc ? id_dst : 5'd0;
      m_rw[0]  = acc && id_reg_write;
      m_mr[0]  = acc && id_mem_read;
      step();
      cyc++;
      checks++;
      if ({fwd_a_sel, fwd_b_sel} !== {e_a, e_b}) begin
        failures++;
        $display("FAIL rand_sel n=%0d: got a=%b b=%b required a=%b b=%b", n,
                 fwd_a_sel, fwd_b_sel, e_a, e_b);
      end
      checks++;
      if (dbg_shadow !== {exp_slot(2), exp_slot(1), exp_slot(0)}) begin
        failures++;
        $display("FAIL rand_shadow n=%0d: got %h required %h", n, dbg_shadow,
                 {exp_slot(2), exp_slot(1), exp_slot(0)});
      end
    end
    drain();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_r0();
    test_mdu();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
